// File: rtl/spi_flash_responder.sv
// SPI-flash responder (mode 0, oversampled on clk) for READ/PP/WREN/RDSR/CE,
// backed by an on-chip byte memory with a registered backdoor port.
module spi_flash_responder #(
  parameter int MEM_BYTES   = 256,
  parameter int PAGE_BYTES  = 256,
  parameter int PROG_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         f_sclk,
  input  logic                         f_cs,
  input  logic                         f_mosi,
  output logic                         f_miso,
  output logic                         busy,
  input  logic [$clog2(MEM_BYTES)-1:0] bd_addr,
  input  logic                         bd_we,
  input  logic [7:0]                   bd_wdata,
  output logic [7:0]                   bd_rdata
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(PROG_CYCLES + 1);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PROG  = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_ERASE = 8'h60;

  typedef enum logic [2:0] {
    P_IDLE, P_CMD, P_ADDR, P_READ, P_PROG, P_STATUS, P_CMDONLY, P_IGNORE
  } p_state_t;
  typedef enum logic [1:0] {B_IDLE, B_PROG, B_ERASE} b_state_t;

  p_state_t p_state, p_next;
  b_state_t b_state, b_next;

  logic [1:0]    sclk_s, cs_s, mosi_s;
  logic          sclk_d, cs_d;
  logic          cs_n, mosi, sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [5:0]    bit_cnt;
  logic          bit_ovf;
  logic [6:0]    rx_sh;
  logic [7:0]    rx_byte, cmd, rd_byte, tx_byte;
  logic          byte_done;
  logic [AW-1:0] addr, prog_next_addr;
  logic [6:0]    tx_sh;
  logic          prog_any, spi_we;
  logic          wel, wip;
  logic          cmd_exact, wren_done, start_erase, start_prog;
  logic [CW-1:0] prog_cnt;
  logic [AW-1:0] erase_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem [MEM_BYTES];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_s <= 2'b00;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[0], f_sclk};
      cs_s   <= {cs_s[0], f_cs};
      mosi_s <= {mosi_s[0], f_mosi};
      sclk_d <= sclk_s[1];
      cs_d   <= cs_s[1];
    end
  end

  assign cs_n      = cs_s[1];
  assign mosi      = mosi_s[1];
  assign sclk_rise = ~cs_n & sclk_s[1] & ~sclk_d;
  assign sclk_fall = ~cs_n & ~sclk_s[1] & sclk_d;
  assign cs_fall   = ~cs_s[1] & cs_d;
  assign cs_rise   = cs_s[1] & ~cs_d;

  assign rx_byte   = {rx_sh, mosi};
  assign byte_done = sclk_rise && (bit_cnt[2:0] == 3'd7);
  assign tx_byte   = (p_state == P_READ) ? rd_byte : {6'b0, wel, wip};
  assign spi_we    = byte_done && (p_state == P_PROG);
  // Program address walks within its page; the page bits stay put.
  assign prog_next_addr = (addr & ~PAGE_MASK) | ((addr + AW'(1)) & PAGE_MASK);

  // A one-byte command counts only if exactly 8 bits were clocked.
  assign cmd_exact   = (p_state == P_CMDONLY) && (bit_cnt == 6'd8) && !bit_ovf;
  assign wren_done   = cs_rise && cmd_exact && (cmd == OP_WREN);
  assign start_erase = cs_rise && cmd_exact && (cmd == OP_ERASE) && wel && !wip;
  assign start_prog  = cs_rise && (p_state == P_PROG) && prog_any;

  always_comb begin
    p_next = p_state;
    if (cs_n) begin
      p_next = P_IDLE;
    end else begin
      case (p_state)
        P_IDLE: if (cs_fall) p_next = P_CMD;
        P_CMD: begin
          if (byte_done) begin
            case (rx_byte)
              OP_READ:           p_next = wip ? P_IGNORE : P_ADDR;
              OP_PROG:           p_next = (wel && !wip) ? P_ADDR : P_IGNORE;
              OP_RDSR:           p_next = P_STATUS;
              OP_WREN, OP_ERASE: p_next = P_CMDONLY;
              default:           p_next = P_IGNORE;
            endcase
          end
        end
        P_ADDR: if (sclk_rise && bit_cnt == 6'd31)
                  p_next = (cmd == OP_READ) ? P_READ : P_PROG;
        default: p_next = p_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      p_state  <= P_IDLE;
      bit_cnt  <= '0;
      bit_ovf  <= 1'b0;
      rx_sh    <= '0;
      cmd      <= '0;
      addr     <= '0;
      tx_sh    <= '1;
      f_miso   <= 1'b1;
      prog_any <= 1'b0;
    end else begin
      p_state <= p_next;
      if (cs_fall) begin
        bit_cnt  <= '0;
        bit_ovf  <= 1'b0;
        prog_any <= 1'b0;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 6'd1;
        rx_sh   <= rx_byte[6:0];
        if (bit_cnt == 6'd63) bit_ovf <= 1'b1;
      end
      if (byte_done && p_state == P_CMD) cmd <= rx_byte;
      if (sclk_rise && p_state == P_ADDR) addr <= {addr[AW-2:0], mosi};
      if (spi_we) begin
        addr     <= prog_next_addr;
        prog_any <= 1'b1;
      end
      // Byte boundaries reload the shifter: memory prefetch or fresh status.
      if (p_state != P_READ && p_state != P_STATUS) begin
        f_miso <= 1'b1;
      end else if (sclk_fall) begin
        if (bit_cnt[2:0] == 3'd0) begin
          f_miso <= tx_byte[7];
          tx_sh  <= tx_byte[6:0];
          if (p_state == P_READ) addr <= addr + AW'(1);
        end else begin
          f_miso <= tx_sh[6];
          tx_sh  <= {tx_sh[5:0], 1'b1};
        end
      end
    end
  end

  always_comb begin
    b_next = b_state;
    case (b_state)
      B_IDLE: begin
        if (start_erase)     b_next = B_ERASE;
        else if (start_prog) b_next = B_PROG;
      end
      B_PROG:  if (prog_cnt == '0) b_next = B_IDLE;
      B_ERASE: if (erase_addr == AW'(MEM_BYTES - 1)) b_next = B_IDLE;
      default: b_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      b_state    <= B_IDLE;
      prog_cnt   <= '0;
      erase_addr <= '0;
      wel        <= 1'b0;
    end else begin
      b_state <= b_next;
      if (b_state == B_IDLE && b_next == B_PROG) prog_cnt <= CW'(PROG_CYCLES - 1);
      else if (b_state == B_PROG)                prog_cnt <= prog_cnt - CW'(1);
      if (b_state == B_IDLE)       erase_addr <= '0;
      else if (b_state == B_ERASE) erase_addr <= erase_addr + AW'(1);
      if (wren_done) wel <= 1'b1;
      if (b_state != B_IDLE && b_next == B_IDLE) wel <= 1'b0;
    end
  end

  assign wip  = (b_state != B_IDLE);
  assign busy = wip;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bd_addr;
    mem_wdata = bd_wdata;
    if (b_state == B_ERASE) begin
      mem_we    = 1'b1;
      mem_waddr = erase_addr;
      mem_wdata = 8'hFF;
    end else if (spi_we) begin
      mem_we    = 1'b1;
      mem_waddr = addr;
      mem_wdata = rx_byte;
    end else if (bd_we && !wip) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_byte <= mem[addr];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) bd_rdata <= 8'h00;
    else        bd_rdata <= mem[bd_addr];
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: drives SPI mode-0 transactions and the
// backdoor, checking against a byte-array flash model.
module tb_spi_flash_responder;
  localparam int MEM_BYTES   = 256;
  localparam int PAGE_BYTES  = 256;
  localparam int PROG_CYCLES = 64;
  localparam int AW          = $clog2(MEM_BYTES);
  localparam int HP          = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          f_sclk = 1'b0;
  logic          f_cs = 1'b1;
  logic          f_mosi = 1'b0;
  logic          f_miso;
  logic          busy;
  logic [AW-1:0] bd_addr = '0;
  logic          bd_we = 1'b0;
  logic [7:0]    bd_wdata = '0;
  logic [7:0]    bd_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_mem [MEM_BYTES];

  spi_flash_responder #(
    .MEM_BYTES(MEM_BYTES), .PAGE_BYTES(PAGE_BYTES), .PROG_CYCLES(PROG_CYCLES)
  ) dut (
    .clk(clk), .n_rst(n_rst), .f_sclk(f_sclk), .f_cs(f_cs), .f_mosi(f_mosi),
    .f_miso(f_miso), .busy(busy), .bd_addr(bd_addr), .bd_we(bd_we),
    .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  always #5 clk = ~clk;

  function automatic int prog_addr(input int base, input int i);
    return (base / PAGE_BYTES) * PAGE_BYTES + ((base + i) % PAGE_BYTES);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    wait_clk(2 * HP);
    f_cs = 1'b0;
    wait_clk(HP);
  endtask

  task automatic cs_high();
    wait_clk(HP);
    f_cs = 1'b1;
  endtask

  task automatic spi_bits(input int n, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      f_mosi = tx[i];
      wait_clk(HP);
      f_sclk = 1'b1;
      rx = {rx[30:0], f_miso};
      wait_clk(HP);
      f_sclk = 1'b0;
    end
  endtask

  task automatic spi_tx(input int n, input logic [31:0] tx);
    logic [31:0] r;
    spi_bits(n, tx, r);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic [31:0] r;
    spi_bits(8, {24'b0, tx}, r);
    rx = r[7:0];
  endtask

  task automatic read_start(input int a);
    cs_low();
    spi_tx(8, 32'h03);
    spi_tx(24, 32'(a));
  endtask

  task automatic do_wren();
    cs_low();
    spi_tx(8, 32'h06);
    cs_high();
  endtask

  task automatic read_status(output logic [7:0] s);
    cs_low();
    spi_tx(8, 32'h05);
    spi_byte(8'h00, s);
    cs_high();
  endtask

  task automatic bd_write(input int a, input logic [7:0] d);
    bd_addr = AW'(a);
    bd_wdata = d;
    bd_we = 1'b1;
    wait_clk(1);
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input int a, output logic [7:0] d);
    bd_addr = AW'(a);
    wait_clk(1);
    d = bd_rdata;
  endtask

  task automatic wait_busy_done(output int cycles, output bit timed_out);
    int w;
    w = 0;
    cycles = 0;
    timed_out = 1'b0;
    while (busy !== 1'b1 && w < 40) begin wait_clk(1); w++; end
    if (busy !== 1'b1) timed_out = 1'b1;
    else while (busy === 1'b1 && cycles < 5000) begin cycles++; wait_clk(1); end
    if (cycles >= 5000) timed_out = 1'b1;
  endtask

  task automatic do_reset();
    f_cs = 1'b1;
    f_sclk = 1'b0;
    n_rst = 1'b0;
    wait_clk(3);
    n_rst = 1'b1;
    wait_clk(2);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    wait_clk(3);
    n_checks++; if (f_miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b expected 1", f_miso); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (bd_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_bd_rdata: got %h expected 00", bd_rdata); end
    n_rst = 1'b1;
    wait_clk(2);
  endtask

  task automatic test_read_wrap();
    logic [7:0] d, exp;
    for (int i = 0; i < MEM_BYTES; i++) begin
      bd_write(i, 8'(i));
      model_mem[i] = 8'(i);
    end
    read_start(32'h0000FE);
    for (int k = 0; k < 3; k++) begin
      spi_byte(8'h00, d);
      exp = model_mem[(32'hFE + k) % MEM_BYTES];
      n_checks++; if (d !== exp) begin n_fail++; $display("FAIL read_wrap[%0d]: got %h expected %h", k, d, exp); end
    end
    cs_high();
  endtask

  task automatic test_status();
    logic [7:0] s;
    read_status(s);
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL status_after_reset: got %h expected 00", s); end
    cs_low(); spi_tx(5, 32'h00); cs_high();
    read_status(s);
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL status_wren_5bits: got %h expected 00", s); end
    cs_low(); spi_tx(9, {23'b0, 8'h06, 1'b0}); cs_high();
    read_status(s);
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL status_wren_9bits: got %h expected 00", s); end
    do_wren();
    cs_low();
    spi_tx(8, 32'h05);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, s);
      n_checks++; if (s !== 8'h02) begin n_fail++; $display("FAIL status_after_wren[%0d]: got %h expected 02", k, s); end
    end
    cs_high();
    do_reset();
  endtask

  task automatic test_prog_no_wren();
    logic [7:0] s, d;
    cs_low(); spi_tx(8, 32'h02); spi_tx(24, 32'h10); spi_tx(8, 32'hA5); cs_high();
    wait_clk(20);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prog_no_wren_busy: got %b expected 0", busy); end
    bd_read(32'h10, d);
    n_checks++; if (d !== model_mem[16]) begin n_fail++; $display("FAIL prog_no_wren_mem: got %h expected %h", d, model_mem[16]); end
    read_status(s);
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL prog_no_wren_status: got %h expected 00", s); end
  endtask

  task automatic test_prog_wrap();
    logic [7:0] s, d;
    logic [7:0] data [3];
    int cycles, a;
    bit to;
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
    do_wren();
    cs_low();
    spi_tx(8, 32'h02);
    spi_tx(24, 32'hFE);
    for (int k = 0; k < 3; k++) spi_tx(8, {24'b0, data[k]});
    spi_tx(4, 32'hF);
    cs_high();
    wait_busy_done(cycles, to);
    n_checks++; if (to || cycles != PROG_CYCLES) begin n_fail++; $display("FAIL prog_busy_cycles: got %0d (timeout %0d) expected %0d", cycles, to, PROG_CYCLES); end
    for (int k = 0; k < 3; k++) model_mem[prog_addr(32'hFE, k)] = data[k];
    read_status(s);
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL prog_status_after: got %h expected 00", s); end
    for (int k = 0; k < 4; k++) begin
      a = prog_addr(32'hFE, k);
      bd_read(a, d);
      n_checks++; if (d !== model_mem[a]) begin n_fail++; $display("FAIL prog_mem[%0h]: got %h expected %h", a, d, model_mem[a]); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] s, d;
    int a;
    read_start(32'h40);
    spi_tx(4, 32'h0);
    n_rst = 1'b0;
    wait_clk(2);
    n_checks++; if (f_miso !== 1'b1) begin n_fail++; $display("FAIL midreset_miso: got %b expected 1", f_miso); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    f_cs = 1'b1;
    f_sclk = 1'b0;
    wait_clk(2);
    n_rst = 1'b1;
    wait_clk(2);
    read_status(s);
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL midreset_status: got %h expected 00", s); end
    a = int'($urandom_range(0, MEM_BYTES - 1));
    read_start(a);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, d);
      n_checks++; if (d !== model_mem[(a + k) % MEM_BYTES]) begin n_fail++; $display("FAIL midreset_read[%0d]: got %h expected %h", k, d, model_mem[(a + k) % MEM_BYTES]); end
    end
    cs_high();
  endtask

  task automatic test_random();
    logic [7:0] d, v;
    int a, len, cycles;
    bit to;
    logic [7:0] data [3];
    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(0, MEM_BYTES - 1));
      v = 8'($urandom);
      bd_write(a, v);
      model_mem[a] = v;
    end
    for (int t = 0; t < 4; t++) begin
      a = int'($urandom_range(0, MEM_BYTES - 1));
      len = int'($urandom_range(1, 3));
      read_start(a);
      for (int k = 0; k < len; k++) begin
        spi_byte(8'h00, d);
        n_checks++; if (d !== model_mem[(a + k) % MEM_BYTES]) begin n_fail++; $display("FAIL rand_read t%0d b%0d: got %h expected %h", t, k, d, model_mem[(a + k) % MEM_BYTES]); end
      end
      cs_high();
    end
    for (int t = 0; t < 2; t++) begin
      a = int'($urandom_range(0, MEM_BYTES - 1));
      len = int'($urandom_range(1, 3));
      for (int k = 0; k < 3; k++) data[k] = 8'($urandom);
      do_wren();
      cs_low();
      spi_tx(8, 32'h02);
      spi_tx(24, 32'(a));
      for (int k = 0; k < len; k++) spi_tx(8, {24'b0, data[k]});
      cs_high();
      wait_busy_done(cycles, to);
      n_checks++; if (to || cycles != PROG_CYCLES) begin n_fail++; $display("FAIL rand_prog_busy t%0d: got %0d expected %0d", t, cycles, PROG_CYCLES); end
      for (int k = 0; k < len; k++) model_mem[prog_addr(a, k)] = data[k];
      for (int k = 0; k < len; k++) begin
        bd_read(prog_addr(a, k), d);
        n_checks++; if (d !== model_mem[prog_addr(a, k)]) begin n_fail++; $display("FAIL rand_prog_mem t%0d b%0d: got %h expected %h", t, k, d, model_mem[prog_addr(a, k)]); end
      end
    end
  endtask

  task automatic test_erase();
    logic [7:0] s_mid, s, d;
    int cycles;
    bit to;
    do_wren();
    cs_low(); spi_tx(8, 32'h60); cs_high();
    fork
      wait_busy_done(cycles, to);
      begin wait_clk(6); read_status(s_mid); end
    join
    n_checks++; if (to || cycles != MEM_BYTES) begin n_fail++; $display("FAIL erase_busy_cycles: got %0d (timeout %0d) expected %0d", cycles, to, MEM_BYTES); end
    n_checks++; if (s_mid !== 8'h03) begin n_fail++; $display("FAIL erase_status_mid: got %h expected 03", s_mid); end
    for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'hFF;
    read_status(s);
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL erase_status_after: got %h expected 00", s); end
    for (int i = 0; i < MEM_BYTES; i++) begin
      bd_read(i, d);
      n_checks++; if (d !== model_mem[i]) begin n_fail++; $display("FAIL erase_mem[%0h]: got %h expected %h", i, d, model_mem[i]); end
    end
  endtask

  task automatic test_erase_blocks();
    logic [7:0] d, v;
    int w;
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom_range(0, 254));
      bd_write(i, v);
    end
    do_wren();
    cs_low(); spi_tx(8, 32'h60); cs_high();
    w = 0;
    while (busy !== 1'b1 && w < 40) begin wait_clk(1); w++; end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL erase2_start: got busy %b expected 1", busy); end
    wait_clk(4);
    bd_write(0, 8'h5A);
    read_start(0);
    spi_byte(8'h00, d);
    cs_high();
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL erase2_read_mid: got %h expected ff", d); end
    w = 0;
    while (busy === 1'b1 && w < 1000) begin wait_clk(1); w++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL erase2_end: got busy %b expected 0", busy); end
    for (int i = 0; i < 16; i++) begin
      bd_read(i, d);
      n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL erase2_mem[%0h]: got %h expected ff", i, d); end
    end
  endtask

  initial begin
    test_reset();
    test_read_wrap();
    test_status();
    test_prog_no_wren();
    test_prog_wrap();
    test_reset_mid_read();
    test_random();
    test_erase();
    test_erase_blocks();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
